// File: rtl/serial_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, registered
// one-cycle strobes for a good byte (new_data) or a bad stop bit (frame_err).
module serial_rx #(
  parameter int CLK_PER_BIT = 100,
  parameter int CTR_SIZE    = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       new_data,
  output logic       frame_err
);

  localparam logic [CTR_SIZE-1:0] BIT_END  = CTR_SIZE'(CLK_PER_BIT - 1);
  localparam logic [CTR_SIZE-1:0] HALF_END = CTR_SIZE'(CLK_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CTR_SIZE-1:0] ctr_q, ctr_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          data_q, data_d;
  logic                nd_q, nd_d;
  logic                fe_q, fe_d;
  logic                rx_meta_q, rx_s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ctr_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      nd_q      <= 1'b0;
      fe_q      <= 1'b0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      nd_q      <= nd_d;
      fe_q      <= fe_d;
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    nd_d    = 1'b0;
    fe_d    = 1'b0;
    case (state_q)
      IDLE: begin
        ctr_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        // Re-check the line at mid start bit; a high here was a glitch.
        if (ctr_q == HALF_END) begin
          ctr_d   = '0;
          bit_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end
      DATA: begin
        if (ctr_q == BIT_END) begin
          ctr_d          = '0;
          shift_d[bit_q] = rx_s_q;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end
      STOP: begin
        if (ctr_q == BIT_END) begin
          ctr_d = '0;
          if (rx_s_q) begin
            data_d  = shift_q;
            nd_d    = 1'b1;
            state_d = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        // Hold off through a break so it reports only once.
        ctr_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        ctr_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign data      = data_q;
  assign new_data  = nd_q;
  assign frame_err = fe_q;

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx: one instance at 8 clk/bit, one at 9 clk/bit.
module tb_serial_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx8 = 1'b1;
  logic       rx9 = 1'b1;
  logic [7:0] data8, data9;
  logic       nd8, fe8, nd9, fe9;

  serial_rx #(.CLK_PER_BIT(8), .CTR_SIZE(4)) dut8 (
    .clk(clk), .rst(rst), .rx(rx8), .data(data8), .new_data(nd8), .frame_err(fe8)
  );
  serial_rx #(.CLK_PER_BIT(9), .CTR_SIZE(4)) dut9 (
    .clk(clk), .rst(rst), .rx(rx9), .data(data9), .new_data(nd9), .frame_err(fe9)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int miss = 0;
  int cyc  = 0;
  int nd8_cnt = 0, fe8_cnt = 0, nd9_cnt = 0, fe9_cnt = 0;
  int nd8_cyc = 0, nd9_cyc = 0;
  int viol = 0;
  logic [7:0] log8[$];
  logic prev8 = 1'b0, prev9 = 1'b0, rst_e = 1'b1;
  logic [7:0] dprev8 = 8'h00, dprev9 = 8'h00;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_e <= rst;
  end

  // Strobe bookkeeping plus protocol rules: never both, never back-to-back,
  // data moves only with new_data.
  always @(negedge clk) begin
    if (nd8) begin nd8_cnt++; nd8_cyc = cyc; log8.push_back(data8); end
    if (fe8) fe8_cnt++;
    if (nd9) begin nd9_cnt++; nd9_cyc = cyc; end
    if (fe9) fe9_cnt++;
    if (nd8 && fe8) viol++;
    if (nd9 && fe9) viol++;
    if ((nd8 || fe8) && prev8) viol++;
    if ((nd9 || fe9) && prev9) viol++;
    if (!rst_e && !nd8 && data8 !== dprev8) viol++;
    if (!rst_e && !nd9 && data9 !== dprev9) viol++;
    prev8  = nd8 || fe8;
    prev9  = nd9 || fe9;
    dprev8 = data8;
    dprev9 = data9;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // cpb doubles as the instance selector (8 or 9).
  task automatic drive(input int cpb, input logic v, input int n);
    if (cpb == 9) rx9 = v;
    else          rx8 = v;
    idle(n);
  endtask

  task automatic send(input int cpb, input logic [7:0] b, input logic stop,
                      input int start_len, output int t0);
    t0 = cyc;
    drive(cpb, 1'b0, start_len);
    for (int i = 0; i < 8; i++) drive(cpb, b[i], cpb);
    drive(cpb, stop, cpb);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(3);
    vecs++; if (data8 !== 8'h00) begin miss++; $display("FAIL reset_data8 got %h want 00", data8); end
    vecs++; if ({nd8, fe8, nd9, fe9} !== 4'b0000) begin miss++; $display("FAIL reset_strobes got %b want 0000", {nd8, fe8, nd9, fe9}); end
    vecs++; if (data9 !== 8'h00) begin miss++; $display("FAIL reset_data9 got %h want 00", data9); end
    rst = 1'b0;
    idle(6);
    vecs++; if (nd8_cnt + fe8_cnt + nd9_cnt + fe9_cnt !== 0) begin miss++; $display("FAIL reset_quiet got %0d strobes want 0", nd8_cnt + fe8_cnt + nd9_cnt + fe9_cnt); end
  endtask

  task automatic test_single;
    int t0;
    int nb = nd8_cnt;
    int fb = fe8_cnt;
    send(8, 8'h31, 1'b1, 8, t0);
    idle(8);
    vecs++; if (nd8_cnt - nb !== 1) begin miss++; $display("FAIL single_nd_count got %0d want 1", nd8_cnt - nb); end
    vecs++; if (data8 !== 8'h31) begin miss++; $display("FAIL single_data got %h want 31", data8); end
    vecs++; if (fe8_cnt - fb !== 0) begin miss++; $display("FAIL single_fe got %0d want 0", fe8_cnt - fb); end
    vecs++; if (nd8_cyc - t0 !== 79) begin miss++; $display("FAIL single_latency got %0d want 79", nd8_cyc - t0); end
  endtask

  task automatic test_odd_skew;
    int t0;
    int lens[3] = '{9, 11, 7};
    for (int k = 0; k < 3; k++) begin
      int nb = nd9_cnt;
      int fb = fe9_cnt;
      send(9, 8'h31, 1'b1, lens[k], t0);
      idle(9);
      vecs++; if (nd9_cnt - nb !== 1) begin miss++; $display("FAIL odd_nd_count start_len=%0d got %0d want 1", lens[k], nd9_cnt - nb); end
      vecs++; if (data9 !== 8'h31) begin miss++; $display("FAIL odd_data start_len=%0d got %h want 31", lens[k], data9); end
      vecs++; if (fe9_cnt - fb !== 0) begin miss++; $display("FAIL odd_fe start_len=%0d got %0d want 0", lens[k], fe9_cnt - fb); end
      if (k == 0) begin
        vecs++; if (nd9_cyc - t0 !== 88) begin miss++; $display("FAIL odd_latency got %0d want 88", nd9_cyc - t0); end
      end
    end
  endtask

  task automatic test_glitch;
    int t0;
    int nb = nd8_cnt;
    int fb = fe8_cnt;
    drive(8, 1'b0, 2);
    drive(8, 1'b1, 6);
    vecs++; if (nd8_cnt - nb !== 0 || fe8_cnt - fb !== 0) begin miss++; $display("FAIL glitch_quiet got nd=%0d fe=%0d want 0 0", nd8_cnt - nb, fe8_cnt - fb); end
    // A frame right after the glitch only decodes if the FSM is back in IDLE.
    send(8, 8'h5A, 1'b1, 8, t0);
    idle(8);
    vecs++; if (data8 !== 8'h5A || nd8_cnt - nb !== 1) begin miss++; $display("FAIL glitch_followup got %h/%0d want 5a/1", data8, nd8_cnt - nb); end
  endtask

  task automatic test_back_to_back;
    int t0;
    int nb = nd8_cnt;
    int qb = log8.size();
    send(8, 8'h30, 1'b1, 8, t0);
    send(8, 8'h31, 1'b1, 8, t0);
    idle(8);
    vecs++; if (nd8_cnt - nb !== 2) begin miss++; $display("FAIL b2b_count got %0d want 2", nd8_cnt - nb); end
    vecs++; if (log8[qb] !== 8'h30) begin miss++; $display("FAIL b2b_first got %h want 30", log8[qb]); end
    vecs++; if (log8[qb+1] !== 8'h31) begin miss++; $display("FAIL b2b_second got %h want 31", log8[qb+1]); end
  endtask

  task automatic test_frame_err;
    int t0;
    int nb = nd8_cnt;
    int fb = fe8_cnt;
    send(8, 8'h55, 1'b0, 8, t0);
    drive(8, 1'b0, 100);
    drive(8, 1'b1, 10);
    vecs++; if (fe8_cnt - fb !== 1) begin miss++; $display("FAIL ferr_count got %0d want 1", fe8_cnt - fb); end
    vecs++; if (nd8_cnt - nb !== 0) begin miss++; $display("FAIL ferr_no_nd got %0d want 0", nd8_cnt - nb); end
    vecs++; if (data8 !== 8'h31) begin miss++; $display("FAIL ferr_data_hold got %h want 31", data8); end
    send(8, 8'h0A, 1'b1, 8, t0);
    idle(8);
    vecs++; if (data8 !== 8'h0A || nd8_cnt - nb !== 1) begin miss++; $display("FAIL ferr_recover got %h/%0d want 0a/1", data8, nd8_cnt - nb); end
  endtask

  task automatic test_rst_mid;
    int t0;
    int nb, fb;
    logic [7:0] aa = 8'hAA;
    drive(8, 1'b0, 8);
    for (int i = 0; i < 4; i++) drive(8, aa[i], 8);
    drive(8, aa[4], 3);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    rx8 = 1'b1;
    nb = nd8_cnt;
    fb = fe8_cnt;
    vecs++; if (data8 !== 8'h00) begin miss++; $display("FAIL rst_mid_data got %h want 00", data8); end
    idle(100);
    vecs++; if (nd8_cnt - nb !== 0 || fe8_cnt - fb !== 0 || data8 !== 8'h00) begin miss++; $display("FAIL rst_mid_quiet got nd=%0d fe=%0d data=%h want 0 0 00", nd8_cnt - nb, fe8_cnt - fb, data8); end
    send(8, 8'h41, 1'b1, 8, t0);
    idle(8);
    vecs++; if (data8 !== 8'h41 || nd8_cnt - nb !== 1 || fe8_cnt - fb !== 0) begin miss++; $display("FAIL rst_mid_frame got %h nd=%0d fe=%0d want 41 1 0", data8, nd8_cnt - nb, fe8_cnt - fb); end
  endtask

  task automatic test_strobe_rules;
    vecs++; if (viol !== 0) begin miss++; $display("FAIL strobe_rules got %0d violations want 0", viol); end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset;
    test_single;
    test_odd_skew;
    test_glitch;
    test_back_to_back;
    test_frame_err;
    test_rst_mid;
    test_strobe_rules;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
